dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra wait cycles inserted before each response (0..15).
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  initiator request; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; latched with req.
REQ-007 addr  input  32  byte address; latched with req.
REQ-008 bit_type  input  3  000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; others illegal.
REQ-009 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]); latched with req.
REQ-010 pc  input  32  initiator PC, latched with req; used only for the display log.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 ack  output  1  one-cycle response strobe.
REQ-013 rdata  output  32  load result, valid only while ack=1; otherwise 0.
REQ-014 err  output  1  valid only while ack=1; 1 = request rejected.

Function
REQ-015 States: IDLE, WAIT, RESP; reset enters IDLE.
REQ-016 IDLE with req=1 at edge k: latch we/addr/bit_type/wdata/pc, load wait counter with WAIT_CYCLES, go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 WAIT: counter decrements each edge; at the edge where the counter is 1, transition to RESP.
REQ-018 ack is asserted exactly during the RESP cycle, i.e. WAIT_CYCLES+1 cycles after the accepting edge; RESP always returns to IDLE next edge.
REQ-019 req is ignored in WAIT and RESP; a new request is accepted earliest at the edge that ends RESP+1 (IDLE cycle), giving a minimum period of WAIT_CYCLES+2 cycles.
REQ-020 Error if bit_type illegal, half address addr[0]!=0, word address addr[1:0]!=0, or addr >= 4*DEPTH_WORDS; on error no storage change, rdata=0, err=1.
REQ-021 Word index = addr[31:2]; byte lane = addr[1:0]; half lane = addr[1].
REQ-022 Store commits at the edge entering RESP: word replaces all 32 bits; half/byte performs read-modify-write, only the selected lane changes.
REQ-023 Load: word returned unchanged; half/byte lane shifted to bit 0, zero-extended (unsigned) or sign-extended (signed) to 32 bits.
REQ-024 Store returns rdata=0, err=0 on success.
REQ-025 Loads observe all stores committed at or before the accepting edge.

Reset
REQ-026 reset=1 at any edge: state IDLE, busy=0, ack=0, rdata=0, err=0, counter=0, every storage word 0.
REQ-027 reset during WAIT or RESP aborts the transaction: no store commits, no ack is produced.
REQ-028 reset has priority over req in the same cycle.

Configuration
REQ-029 Macro DM_RESPONDER_DISPLAY_EN defined: each committed store prints one line "@<pc>: *<word byte address> <= <full merged word>" (8-digit hex, word address = addr with [1:0] cleared) in the committing cycle.
REQ-030 DM_RESPONDER_DISPLAY_EN undefined: no display logic; cycle behaviour identical.

Verification
REQ-031 WAIT_CYCLES=2; store word 0x12345678 at 0x10, pc 0x3000 -> ack exactly 3 cycles after acceptance, err=0; with macro, log "@00003000: *00000010 <= 12345678".
REQ-032 Then store byte 0xAB at 0x13, then load byte signed at 0x13 -> rdata 0xFFFFFFAB; load word at 0x10 -> 0xAB345678.
REQ-033 Load half unsigned at 0x12 after REQ-032 -> 0x0000AB34; half signed -> 0xFFFFAB34.
REQ-034 Store word at 0x11, half at 0x01, bit_type 111, addr 0x1000 -> each ack with err=1, rdata=0, memory unchanged (load word 0x10 still 0xAB345678).
REQ-035 Hold req=1 continuously -> accepts only in IDLE, ack period 4 cycles, busy high 3 of every 4 cycles; WAIT_CYCLES=0 -> ack 1 cycle after acceptance, period 2.
REQ-036 Accept store 0xDEADBEEF at 0x20, assert reset in WAIT -> no ack; after reset, load word 0x20 -> 0x00000000.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: fixed-latency data-memory responder with word/half/byte access.
// Optional store log enabled by defining DM_RESPONDER_DISPLAY_EN.
module dm_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [2:0]  bit_type,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic        busy,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        l_we;
   logic [31:0] l_addr;
   logic [2:0]  l_bt;
   logic [31:0] l_wdata;
   logic [31:0] l_pc;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [31:0] mem [0:DEPTH_WORDS-1];

   logic        accept;
   logic        finish;
   logic        op_we;
   logic [31:0] op_addr;
   logic [2:0]  op_bt;
   logic [31:0] op_wdata;
   logic [31:0] op_pc;
   logic        is_word;
   logic        is_half;
   logic        is_byte;
   logic        sgn;
   logic        misalign;
   logic        oob;
   logic        op_err;
   logic [AW-1:0] idx;
   logic [31:0] old;
   logic [15:0] lane_h;
   logic [7:0]  lane_b;
   logic [31:0] merged;
   logic [31:0] ldata;

   assign accept = (state == S_IDLE) && req;

   // With zero wait cycles the access completes on the accepting edge,
   // so operands come straight from the ports while still in IDLE.
   assign finish = (accept && (WAIT_INIT == 4'd0))
                 || ((state == S_WAIT) && (cnt == 4'd1));

   assign op_we    = (state == S_IDLE) ? we       : l_we;
   assign op_addr  = (state == S_IDLE) ? addr     : l_addr;
   assign op_bt    = (state == S_IDLE) ? bit_type : l_bt;
   assign op_wdata = (state == S_IDLE) ? wdata    : l_wdata;
   assign op_pc    = (state == S_IDLE) ? pc       : l_pc;

   // Decode access size, alignment and range of the current operation
   always_comb begin
      is_word  = 1'b0;
      is_half  = 1'b0;
      is_byte  = 1'b0;
      sgn      = 1'b0;
      case (op_bt)
         3'b000: is_word = 1'b1;
         3'b001: is_half = 1'b1;
         3'b010: begin is_half = 1'b1; sgn = 1'b1; end
         3'b011: is_byte = 1'b1;
         3'b100: begin is_byte = 1'b1; sgn = 1'b1; end
         default: ;
      endcase
      misalign = (is_word && (op_addr[1:0] != 2'b00))
               || (is_half && op_addr[0]);
      oob      = {1'b0, op_addr} >= LIMIT;
      op_err   = !(is_word || is_half || is_byte) || misalign || oob;
   end

   assign idx    = op_addr[AW+1:2];
   assign old    = mem[idx];
   assign lane_h = op_addr[1] ? old[31:16] : old[15:0];
   assign lane_b = old[{op_addr[1:0], 3'b000} +: 8];

   // Build the merged store word and the extended load value
   always_comb begin
      merged = old;
      ldata  = old;
      unique case (1'b1)
         is_word: begin
            merged = op_wdata;
            ldata  = old;
         end
         is_half: begin
            merged[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
            ldata = sgn ? {{16{lane_h[15]}}, lane_h}
                        : {16'h0000, lane_h};
         end
         is_byte: begin
            merged[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            ldata = sgn ? {{24{lane_b[7]}}, lane_b}
                        : {24'h000000, lane_b};
         end
         default: begin
            merged = old;
            ldata  = 32'h0;
         end
      endcase
   end

   // Control FSM, wait counter and request latch
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         l_we    <= 1'b0;
         l_addr  <= 32'h0;
         l_bt    <= 3'd0;
         l_wdata <= 32'h0;
         l_pc    <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  l_we    <= we;
                  l_addr  <= addr;
                  l_bt    <= bit_type;
                  l_wdata <= wdata;
                  l_pc    <= pc;
                  cnt     <= WAIT_INIT;
                  state   <= (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Storage: cleared on reset, committed on the edge entering RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
      end else if (finish && op_we && !op_err) begin
         mem[idx] <= merged;
      end
   end

   // Capture the response presented during RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_data <= 32'h0;
         resp_err  <= 1'b0;
      end else if (finish) begin
         resp_data <= (op_we || op_err) ? 32'h0 : ldata;
         resp_err  <= op_err;
      end
   end

   assign busy  = (state != S_IDLE);
   assign ack   = (state == S_RESP);
   assign rdata = ack ? resp_data : 32'h0;
   assign err   = ack && resp_err;

`ifdef DM_RESPONDER_DISPLAY_EN
   // Log every committed store with its full merged word
   always_ff @(posedge clk) begin
      if (!reset && finish && op_we && !op_err)
         $display("@%08h: *%08h <= %08h", op_pc,
                  {op_addr[31:2], 2'b00}, merged);
   end
`else
   logic unused_pc;
   assign unused_pc = ^op_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed table, corner sequences and random
// transactions checked against a byte-addressed reference memory.
module tb_dm_responder;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        reset, req, we;
   logic [31:0] addr, wdata, pc;
   logic [2:0]  bit_type;
   logic        busy, ack, err;
   logic [31:0] rdata;

   logic        req0, we0;
   logic [31:0] addr0, wdata0, pc0;
   logic [2:0]  bit_type0;
   logic        busy0, ack0, err0;
   logic [31:0] rdata0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mb [0:4095];

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [2:0]  t;
      logic [31:0] d;
      logic [31:0] p;
      logic [31:0] er_d;
      logic        ee;
   } vec_t;

   vec_t tbl [0:17];

   always #5 clk = ~clk;

   dm_responder #(.WAIT_CYCLES(W), .DEPTH_WORDS(1024)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .bit_type(bit_type), .wdata(wdata), .pc(pc), .busy(busy),
      .ack(ack), .rdata(rdata), .err(err)
   );

   dm_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(16)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
      .bit_type(bit_type0), .wdata(wdata0), .pc(pc0), .busy(busy0),
      .ack(ack0), .rdata(rdata0), .err(err0)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
   endfunction

   function automatic void model(input logic w, input logic [31:0] a,
                                 input logic [2:0] t, input logic [31:0] d,
                                 output logic [31:0] rd, output logic er);
      int sz;
      longint v;
      case (t)
         3'd0:       sz = 4;
         3'd1, 3'd2: sz = 2;
         3'd3, 3'd4: sz = 1;
         default:    sz = 0;
      endcase
      er = (sz == 0) || (a >= 32'd4096) || ((a % 32'(sz)) != 0);
      rd = 32'h0;
      if (er) return;
      if (w) begin
         for (int k = 0; k < sz; k++) mb[a + k] = d[8*k +: 8];
      end else begin
         v = 0;
         for (int k = 0; k < sz; k++)
            v = v | (longint'(mb[a + k]) << (8 * k));
         if ((t == 3'd2 || t == 3'd4) && v[8*sz-1])
            v = v | (-64'sd1 << (8 * sz));
         rd = v[31:0];
      end
   endfunction

   task automatic txn(input logic w, input logic [31:0] a,
                      input logic [2:0] t, input logic [31:0] d,
                      input logic [31:0] p, output logic [31:0] rd,
                      output logic er, output int lat);
      int n;
      logic clean;
      clean    = 1'b1;
      we       = w;
      addr     = a;
      bit_type = t;
      wdata    = d;
      pc       = p;
      req      = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      n = 0;
      while (!ack && n < 20) begin
         if (rdata !== 32'h0 || err !== 1'b0) clean = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      lat = ack ? n + 1 : -1;
      rd  = rdata;
      er  = err;
      @(posedge clk); #1;
      chk("ack_one_cycle", {30'h0, ack, busy}, 32'h0);
      chk("quiet_before_ack", {31'h0, clean}, 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat;
      logic [15:0] ack_v, busy_v, ack0_v, busy0_v;
      logic [15:0] e_ack, e_busy, e_ack0, e_busy0;
      logic        any_ack;

      tbl[0]  = '{1'b0, 32'h10,   3'd0, 32'h0,        32'h2000, 32'h0,        1'b0};
      tbl[1]  = '{1'b1, 32'h10,   3'd0, 32'h12345678, 32'h3000, 32'h0,        1'b0};
      tbl[2]  = '{1'b1, 32'h13,   3'd3, 32'h000000AB, 32'h3004, 32'h0,        1'b0};
      tbl[3]  = '{1'b0, 32'h13,   3'd4, 32'h0,        32'h3008, 32'hFFFFFFAB, 1'b0};
      tbl[4]  = '{1'b0, 32'h10,   3'd0, 32'h0,        32'h300C, 32'hAB345678, 1'b0};
      tbl[5]  = '{1'b0, 32'h12,   3'd1, 32'h0,        32'h3010, 32'h0000AB34, 1'b0};
      tbl[6]  = '{1'b0, 32'h12,   3'd2, 32'h0,        32'h3014, 32'hFFFFAB34, 1'b0};
      tbl[7]  = '{1'b1, 32'h11,   3'd0, 32'h11111111, 32'h3018, 32'h0,        1'b1};
      tbl[8]  = '{1'b1, 32'h01,   3'd1, 32'h2222,     32'h301C, 32'h0,        1'b1};
      tbl[9]  = '{1'b1, 32'h10,   3'd7, 32'h33333333, 32'h3020, 32'h0,        1'b1};
      tbl[10] = '{1'b1, 32'h1000, 3'd0, 32'h44444444, 32'h3024, 32'h0,        1'b1};
      tbl[11] = '{1'b0, 32'h10,   3'd0, 32'h0,        32'h3028, 32'hAB345678, 1'b0};
      tbl[12] = '{1'b0, 32'h12,   3'd3, 32'h0,        32'h302C, 32'h00000034, 1'b0};
      tbl[13] = '{1'b1, 32'hFFC,  3'd0, 32'hCAFEF00D, 32'h3030, 32'h0,        1'b0};
      tbl[14] = '{1'b0, 32'hFFE,  3'd2, 32'h0,        32'h3034, 32'hFFFFCAFE, 1'b0};
      tbl[15] = '{1'b0, 32'h1000, 3'd3, 32'h0,        32'h3038, 32'h0,        1'b1};
      tbl[16] = '{1'b1, 32'h10,   3'd1, 32'hFFFF1111, 32'h303C, 32'h0,        1'b0};
      tbl[17] = '{1'b0, 32'h10,   3'd0, 32'h0,        32'h3040, 32'hAB341111, 1'b0};

      reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0;
      bit_type = 3'd0; wdata = 32'h0; pc = 32'h0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0;
      bit_type0 = 3'd0; wdata0 = 32'h0; pc0 = 32'h0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",  {31'h0, busy},  32'h0);
      chk("reset_ack",   {31'h0, ack},   32'h0);
      chk("reset_rdata", rdata,          32'h0);
      chk("reset_err",   {31'h0, err},   32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) begin
         txn(tbl[i].w, tbl[i].a, tbl[i].t, tbl[i].d, tbl[i].p, rd, er, lat);
         model(tbl[i].w, tbl[i].a, tbl[i].t, tbl[i].d, mrd, mer);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(W + 1));
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].er_d);
         chk($sformatf("tbl%0d_err", i), {31'h0, er}, {31'h0, tbl[i].ee});
      end

      // continuous request on both instances
      we = 1'b0; addr = 32'h10; bit_type = 3'd0; req = 1'b1;
      we0 = 1'b0; addr0 = 32'h0; bit_type0 = 3'd0; req0 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         ack_v[i-1]   = ack;
         busy_v[i-1]  = busy;
         ack0_v[i-1]  = ack0;
         busy0_v[i-1] = busy0;
         e_ack[i-1]   = (i >= W + 1) && (((i - (W + 1)) % (W + 2)) == 0);
         e_busy[i-1]  = ((i - 1) % (W + 2)) != (W + 1);
         e_ack0[i-1]  = ((i - 1) % 2) == 0;
         e_busy0[i-1] = ((i - 1) % 2) == 0;
      end
      req = 1'b0; req0 = 1'b0;
      chk("hold_ack_w2",  {16'h0, ack_v},   {16'h0, e_ack});
      chk("hold_busy_w2", {16'h0, busy_v},  {16'h0, e_busy});
      chk("hold_ack_w0",  {16'h0, ack0_v},  {16'h0, e_ack0});
      chk("hold_busy_w0", {16'h0, busy0_v}, {16'h0, e_busy0});
      @(posedge clk); #1;

      // random traffic against the byte model
      for (int i = 0; i < 300; i++) begin
         logic        rw;
         logic [31:0] ra, rdd;
         logic [2:0]  rt;
         rw  = 1'($urandom_range(0, 1));
         rt  = 3'($urandom_range(0, 5));
         rdd = $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'h0FF0 + $urandom_range(0, 31);
         else ra = $urandom_range(0, 63);
         txn(rw, ra, rt, rdd, 32'h8000 + 32'(i), rd, er, lat);
         model(rw, ra, rt, rdd, mrd, mer);
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(W + 1));
         chk($sformatf("rnd%0d_rdata", i), rd, mrd);
         chk($sformatf("rnd%0d_err", i), {31'h0, er}, {31'h0, mer});
      end

      // reset while a store waits: no commit, no ack, reset beats req
      we = 1'b1; addr = 32'h20; bit_type = 3'd0; wdata = 32'hDEADBEEF;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      chk("abort_accepted", {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1; req = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_ack",  {31'h0, ack},  32'h0);
      reset = 1'b0; req = 1'b0;
      model_clear();
      any_ack = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ack || busy) any_ack = 1'b1;
      end
      chk("abort_no_ack", {31'h0, any_ack}, 32'h0);
      txn(1'b0, 32'h20, 3'd0, 32'h0, 32'h5000, rd, er, lat);
      chk("abort_load20", rd, 32'h0);
      chk("abort_err20", {31'h0, er}, 32'h0);
      txn(1'b0, 32'h10, 3'd0, 32'h0, 32'h5004, rd, er, lat);
      chk("reset_cleared10", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
